data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, stall cycles per access (1..15).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_read  input  1  MEM-stage load request.
REQ-006 SHALL have port mem_write  input  1  MEM-stage store request.
REQ-007 SHALL have port addr  input  32  byte address from the ALU result.
REQ-008 SHALL have port wdata  input  32  store data.
REQ-009 SHALL have port rdata  output  32  registered load data.
REQ-010 SHALL have port stall  output  1  combinational hold request to the pipeline (PC, IF/ID, ID/EX, EX/MEM hold).
REQ-011 SHALL have port ack  output  1  one-cycle access-complete pulse.
REQ-012 SHALL have port misalign_err  output  1  one-cycle misaligned-access pulse.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: a request (mem_read or mem_write high) SHALL be accepted, op/addr/wdata captured, counter loaded with LATENCY-1, next state WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-015 WAIT: counter SHALL decrement each cycle; at zero, next state RESP.
REQ-016 RESP: ack=1, stall=0, next state IDLE unconditionally.
REQ-017 stall SHALL equal (state==IDLE and request) or state==WAIT; for a request first seen in cycle N, stall is high in cycles N..N+LATENCY-1 and ack is high in cycle N+LATENCY.
REQ-018 Store SHALL commit to the array on the edge entering RESP; a load issued in the next access SHALL see it.
REQ-019 Load data SHALL be written to rdata on the edge entering RESP and held until the next load completes; stores SHALL not change rdata.
REQ-020 mem_read and mem_write both high SHALL be treated as a store only.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap modulo DEPTH_WORDS).
REQ-022 Request inputs changing or dropping during WAIT SHALL be ignored; the captured access completes.
REQ-023 A request present in the RESP cycle SHALL not be accepted; it is accepted in the following IDLE cycle (back-to-back accesses cost LATENCY+1 cycles).

Reset
REQ-024 Reset SHALL force state IDLE, counter 0, rdata 0, ack 0, misalign_err 0; stall then follows REQ-017 from the next cycle.
REQ-025 Reset during WAIT SHALL abort the access; an uncommitted store SHALL not be written.
REQ-026 Reset SHALL not clear array contents.

Configuration
REQ-027 Macro DMEM_MISALIGN_TRAP_EN defined: accepted access with addr[1:0]!=0 SHALL run full latency, pulse misalign_err with ack in RESP, suppress store, and load rdata with 0.
REQ-028 Macro undefined: addr[1:0] SHALL be ignored and misalign_err tied to 0.

Verification
REQ-029 After reset, store 0xDEADBEEF to 0x10 then load 0x10 (LATENCY=2) -> stall high 2 cycles each, ack in 3rd cycle, rdata=0xDEADBEEF.
REQ-030 Load 0x10 with mem_read dropped in cycle N+1 -> access still completes, ack at N+2, rdata=0xDEADBEEF.
REQ-031 mem_read=mem_write=1, addr 0x20, wdata 0x12345678 -> store only, rdata unchanged; subsequent load 0x20 returns 0x12345678.
REQ-032 Store 0xCAFEF00D to 0x40, reset asserted in WAIT -> ack never pulses; load 0x40 returns prior value.
REQ-033 DEPTH_WORDS=256: store 0xA5A5A5A5 to 0x400, load 0x000 -> 0xA5A5A5A5 (wrap).
REQ-034 With DMEM_MISALIGN_TRAP_EN, store to 0x42 -> misalign_err=1 with ack, memory unchanged; without macro, same store writes word 0x40.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Fixed-latency MEM-stage data memory with stall/ack handshake.
//            Optional misaligned-access trap enabled by DMEM_MISALIGN_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ack,
  output logic        misalign_err
);

  localparam int         c_IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] c_LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic                 store_q;
  logic                 mis_q;
  logic [c_IDX_W-1:0]   idx_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 ack_q;
  logic                 mis_err_q;
  logic [31:0]          mem_q [DEPTH_WORDS];

  logic                 w_req;
  logic                 w_mis_in;
  logic [c_IDX_W-1:0]   w_idx_in;
  logic                 w_enter_resp;
  logic                 w_op_store;
  logic                 w_op_mis;
  logic [c_IDX_W-1:0]   w_op_idx;
  logic [31:0]          w_op_wdata;
  logic                 w_commit;
  logic                 w_unused_addr;

  assign w_req    = mem_read | mem_write;
  assign w_idx_in = addr[c_IDX_W+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_mis_in = (addr[1:0] != 2'b00);
  assign w_unused_addr = ^{addr[31:c_IDX_W+2]};
`else
  assign w_mis_in = 1'b0;
  assign w_unused_addr = ^{addr[31:c_IDX_W+2], addr[1:0]};
`endif

  // With LATENCY=1 the access resolves straight out of IDLE, so the live
  // inputs stand in for the captured operands on that edge.
  assign w_enter_resp = ((state_q == S_IDLE) && w_req && (LATENCY == 1)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd1));
  assign w_op_store   = (state_q == S_IDLE) ? mem_write : store_q;
  assign w_op_mis     = (state_q == S_IDLE) ? w_mis_in  : mis_q;
  assign w_op_idx     = (state_q == S_IDLE) ? w_idx_in  : idx_q;
  assign w_op_wdata   = (state_q == S_IDLE) ? wdata     : wdata_q;
  assign w_commit     = w_enter_resp && w_op_store && !w_op_mis && !reset;

  assign stall        = ((state_q == S_IDLE) && w_req) || (state_q == S_WAIT);
  assign rdata        = rdata_q;
  assign ack          = ack_q;
  assign misalign_err = mis_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      store_q   <= 1'b0;
      mis_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      ack_q     <= 1'b0;
      mis_err_q <= 1'b0;
    end else begin
      ack_q     <= w_enter_resp;
      mis_err_q <= w_enter_resp && w_op_mis;
      if (w_enter_resp && !w_op_store) begin
        rdata_q <= w_op_mis ? 32'd0 : mem_q[w_op_idx];
      end
      case (state_q)
        S_IDLE: begin
          if (w_req) begin
            store_q <= mem_write;
            mis_q   <= w_mis_in;
            idx_q   <= w_idx_in;
            wdata_q <= wdata;
            cnt_q   <= c_LAT_M1;
            state_q <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Array has no reset so contents survive a pipeline flush.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      mem_q[w_op_idx] <= w_op_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Randomized scoreboard bench for data_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ack;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] mdl_rdata;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .ack(ack),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack=1 want no pending access");
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rdata", rdata, e.rdata);
          check("misalign_err", {31'd0, misalign_err}, {31'd0, e.mis});
        end
      end else if (misalign_err) begin
        checks++;
        failures++;
        $display("FAIL stray_misalign: got misalign_err=1 want 0 without ack");
      end
    end
  end

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input bit drop);
    exp_t e;
    int   idx;
    bit   mis;
    int   stalls;
    int   ackc;
    idx = int'((a >> 2) % DEPTH);
    mis = TRAP && (a[1:0] != 2'b00);
    if (wr) begin
      if (!mis) mdl_mem[idx] = d;
    end else begin
      mdl_rdata = mis ? 32'd0 : mdl_mem[idx];
    end
    e.rdata = mdl_rdata;
    e.mis   = mis;
    sb.push_back(e);
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    stalls    = 0;
    ackc      = -1;
    for (int c = 0; c < LAT + 4; c++) begin
      @(negedge clk);
      if (ack) begin
        ackc = c;
        break;
      end
      if (stall) stalls++;
      @(posedge clk); #1;
      if (drop && c == 0) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = $urandom;
        wdata     = $urandom;
      end
    end
    check("ack_cycle", ackc, LAT);
    check("stall_cycles", stalls, LAT);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic reset_in_wait(input logic [31:0] a, input logic [31:0] d);
    mem_read  = 1'b0;
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    @(posedge clk); #1;
    reset     = 1'b1;
    mem_write = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b0;
    mdl_rdata = 32'd0;
    @(negedge clk);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = 32'd0;
    wdata     = 32'd0;
    mdl_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_rdata", rdata, 32'd0);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_misalign", {31'd0, misalign_err}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);

    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h40, 32'h11112222, 1'b0);
    reset_in_wait(32'h40, 32'hCAFEF00D);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b0);
    access(1'b1, 1'b0, 32'h000, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h42, 32'h0BADF00D, 1'b0);
    access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h13, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic        rd, wr;
      logic [31:0] a;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      access(rd, wr, a, $urandom, 1'($urandom));
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(posedge clk);
      #1;
    end

    repeat (LAT + 3) @(posedge clk);
    check("pending_responses", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
